fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the memory wrapper's instruction port. It owns the PC and drives `MEM_RDEN1`/`MEM_ADDR1`, holding each request stable until `memValid1` confirms an L1 hit or a completed fill. Accepted instructions go into a 2-entry buffer that feeds decode, which decouples decode stalls from cache latency. Branch redirects are honoured without disturbing a line fill that is already in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between fetch and decode; flush beats push.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [0:1];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            do_pop  = pop_i && (count_q != 2'd0);
            do_push = push_i && ((count_q != 2'd2) || do_pop);
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is qualified by count, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one read at a time, buffers two words.
// Optional fetch-range fault is enabled by defining FETCH_FAULT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL_ID,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        memValid1,
    output logic        IR_VALID,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic        FETCH_FAULT
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         run_q;
    logic [13:0]  drain_addr_q, drain_addr_d;
    logic [1:0]   count;
    fetch_entry_t head, push_entry;
    logic         issue_ok, fault_block;
    logic         accept, push, pop;

`ifdef FETCH_FAULT_EN
    logic fault_q, fault_d;

    assign fault_block = fault_q || (pc_q >= IMEM_LIMIT);

    always_comb begin
        fault_d = fault_q;
        if (BR_TAKEN)
            fault_d = 1'b0;
        else if ((state_q == FETCH) && run_q && (count != 2'd2) && (pc_q >= IMEM_LIMIT))
            fault_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign FETCH_FAULT = fault_q;
`else
    assign fault_block = 1'b0;
    assign FETCH_FAULT = 1'b0;
`endif

    // run_q keeps the read request low for the first cycle out of reset.
    assign issue_ok  = (state_q == FETCH) && run_q && (count != 2'd2) && !fault_block;
    assign MEM_RDEN1 = (state_q == DRAIN) || issue_ok;
    assign MEM_ADDR1 = (state_q == DRAIN) ? drain_addr_q : pc_q[15:2];

    assign accept = MEM_RDEN1 && memValid1;
    assign push   = accept && (state_q == FETCH) && !BR_TAKEN;
    assign pop    = IR_VALID && !STALL_ID;

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = MEM_DOUT1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            FETCH: begin
                // A redirect with a read still pending must let that read finish untouched.
                if (BR_TAKEN && MEM_RDEN1 && !memValid1) begin
                    state_d      = DRAIN;
                    drain_addr_d = pc_q[15:2];
                end
            end
            DRAIN: begin
                if (accept) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (BR_TAKEN)
            pc_d = BR_TARGET;
        else if (push)
            pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        drain_addr_q <= drain_addr_d;
    end

    fetch_fifo u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (BR_TAKEN),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (count)
    );

    assign IR_VALID = (count != 2'd0);
    assign IR       = IR_VALID ? head.instr : NOP_INSTR;
    assign IR_PC    = IR_VALID ? head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-accurate vector table plus a random-stall scoreboard run.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        STALL_ID;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        MEM_RDEN1;
    logic [13:0] MEM_ADDR1;
    logic [31:0] MEM_DOUT1;
    logic        memValid1;
    logic        IR_VALID;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        FETCH_FAULT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Memory model: each word holds its own word address.
    assign MEM_DOUT1 = {18'h0, MEM_ADDR1};

    fetch_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .STALL_ID    (STALL_ID),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .MEM_RDEN1   (MEM_RDEN1),
        .MEM_ADDR1   (MEM_ADDR1),
        .MEM_DOUT1   (MEM_DOUT1),
        .memValid1   (memValid1),
        .IR_VALID    (IR_VALID),
        .IR          (IR),
        .IR_PC       (IR_PC),
        .FETCH_FAULT (FETCH_FAULT)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        mv;
        logic        e_rden;
        logic [13:0] e_addr;
        logic        e_valid;
        logic [31:0] e_irpc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_q[$];

    task automatic add(input logic rst_n, input logic stall, input logic br, input logic [31:0] tgt,
                       input logic mv, input logic e_rden, input logic [13:0] e_addr,
                       input logic e_valid, input logic [31:0] e_irpc, input logic e_fault);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.br = br; v.tgt = tgt; v.mv = mv;
        v.e_rden = e_rden; v.e_addr = e_addr; v.e_valid = e_valid; v.e_irpc = e_irpc; v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string name, input int row, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0b expected %0b", name, row, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_ir;
        logic [31:0] exp_pc;
        logic        prev_hold;
        logic [13:0] prev_addr;
        int          cyc;

        RST_N = 1'b0; STALL_ID = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 32'h0; memValid1 = 1'b0;

        // rst stall br tgt mv | rden addr valid irpc fault
        add(0,0,0,32'h0,1, 0,14'h0,0,32'h0,0);
        add(0,0,0,32'h0,1, 0,14'h0,0,32'h0,0);
        add(1,0,0,32'h0,1, 0,14'h0,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h0,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h1,1,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h2,1,32'h4,0);
        add(1,0,0,32'h0,1, 1,14'h3,1,32'h8,0);
        add(1,1,0,32'h0,1, 1,14'h4,1,32'hC,0);
        for (int i = 0; i < 4; i++) add(1,1,0,32'h0,1, 0,14'h5,1,32'hC,0);
        add(1,0,0,32'h0,1, 0,14'h5,1,32'hC,0);
        add(1,0,0,32'h0,1, 1,14'h5,1,32'h10,0);
        add(1,0,0,32'h0,1, 1,14'h6,1,32'h14,0);
        add(1,0,0,32'h0,1, 1,14'h7,1,32'h18,0);
        add(1,0,0,32'h0,0, 1,14'h8,1,32'h1C,0);
        for (int i = 0; i < 9; i++) add(1,0,0,32'h0,0, 1,14'h8,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h8,0,32'h0,0);
        add(1,0,0,32'h0,0, 1,14'h9,1,32'h20,0);
        add(1,0,1,32'h40,1, 1,14'h9,0,32'h0,0);
        add(1,0,0,32'h0,0, 1,14'h10,0,32'h0,0);
        add(1,0,1,32'h80,0, 1,14'h10,0,32'h0,0);
        add(1,0,0,32'h0,0, 1,14'h10,0,32'h0,0);
        add(1,0,1,32'h100,0, 1,14'h10,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h10,0,32'h0,0);
        add(1,0,0,32'h0,0, 1,14'h40,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h40,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h41,1,32'h100,0);
        add(1,0,1,32'h300,1, 1,14'h42,1,32'h104,0);
        add(1,0,0,32'h0,1, 1,14'hC0,0,32'h0,0);
        add(1,1,0,32'h0,0, 1,14'hC1,1,32'h300,0);
        add(1,0,0,32'h0,0, 1,14'hC1,1,32'h300,0);
        add(1,0,0,32'h0,0, 1,14'hC1,0,32'h0,0);
        add(0,0,0,32'h0,0, 1,14'hC1,0,32'h0,0);
        add(0,0,0,32'h0,0, 0,14'h0,0,32'h0,0);
        add(1,0,0,32'h0,0, 0,14'h0,0,32'h0,0);
`ifdef FETCH_FAULT_EN
        add(1,0,1,32'h6000,1, 1,14'h0,0,32'h0,0);
        add(1,0,0,32'h0,0, 0,14'h1800,0,32'h0,0);
        add(1,0,0,32'h0,1, 0,14'h1800,0,32'h0,1);
        add(1,0,1,32'h0,1, 0,14'h1800,0,32'h0,1);
        add(1,0,0,32'h0,1, 1,14'h0,0,32'h0,0);
        add(1,1,0,32'h0,0, 1,14'h1,1,32'h0,0);
`else
        add(1,0,1,32'hFFFF_FFFC,1, 1,14'h0,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,14'h3FFF,0,32'h0,0);
        add(1,1,0,32'h0,0, 1,14'h0,1,32'hFFFF_FFFC,0);
`endif

        repeat (2) @(posedge CLK);
        #1;
        foreach (vecs[i]) begin
            RST_N = vecs[i].rst_n; STALL_ID = vecs[i].stall; BR_TAKEN = vecs[i].br;
            BR_TARGET = vecs[i].tgt; memValid1 = vecs[i].mv;
            @(negedge CLK);
            exp_ir = vecs[i].e_valid ? {18'h0, vecs[i].e_irpc[15:2]} : 32'h0000_0013;
            chk1 ("rden",  i, MEM_RDEN1,   vecs[i].e_rden);
            chk32("addr",  i, {18'h0, MEM_ADDR1}, {18'h0, vecs[i].e_addr});
            chk1 ("valid", i, IR_VALID,    vecs[i].e_valid);
            chk32("ir_pc", i, IR_PC,       vecs[i].e_irpc);
            chk32("ir",    i, IR,          exp_ir);
            chk1 ("fault", i, FETCH_FAULT, vecs[i].e_fault);
            @(posedge CLK);
            #1;
        end

        // Random stalls and miss latencies; the in-order PC stream is the expectation.
        RST_N = 1'b0; BR_TAKEN = 1'b0; STALL_ID = 1'b0; memValid1 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int k = 0; k < 40; k++) exp_q.push_back(32'(k * 4));
        prev_hold = 1'b0;
        prev_addr = 14'h0;
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < 3000)) begin
            STALL_ID  = ($urandom_range(0, 9) < 3);
            memValid1 = ($urandom_range(0, 9) < 6);
            @(negedge CLK);
            if (prev_hold) begin
                chk1 ("hold_rden", cyc, MEM_RDEN1, 1'b1);
                chk32("hold_addr", cyc, {18'h0, MEM_ADDR1}, {18'h0, prev_addr});
            end
            if (IR_VALID && !STALL_ID) begin
                exp_pc = exp_q.pop_front();
                chk32("sb_pc", cyc, IR_PC, exp_pc);
                chk32("sb_ir", cyc, IR, {18'h0, exp_pc[15:2]});
            end
            prev_hold = MEM_RDEN1 && !memValid1;
            prev_addr = MEM_ADDR1;
            @(posedge CLK);
            #1;
            cyc++;
        end
        STALL_ID = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_timeout: %0d words still expected after %0d cycles, required 0", exp_q.size(), cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
